// File: rtl/stage5_message_queue_module_pkg.sv
// Shared widths, group-word layout and read-FSM state type for the stage 5 message queue.
// Optional slot skipping is selected with the STAGE5_SLOT_SKIP_EN macro in the top module.
package stage5_message_queue_module_pkg;

    localparam int MAX_MESSAGE_BITS          = 32;
    localparam int N_type_control_width      = 4;
    localparam int message_mux_control_width = 3;

    localparam int stage5_fifo_depth = 8;
    localparam int stage5_fifo_aw    = 3;
    localparam int overflow_cnt_bits = 16;

    // One slot as stored in the FIFO; slot 1 sits at group index 0.
    typedef struct packed {
        logic [message_mux_control_width-1:0] mux;
        logic [N_type_control_width-1:0]      n_type;
        logic [MAX_MESSAGE_BITS-1:0]          data;
    } slot_t;

    typedef slot_t [2:0] group_t;

    localparam int stage5_group_bits = $bits(group_t);

    typedef enum logic {
        IDLE,
        EMIT
    } rd_state_t;

    function automatic logic group_has_msg(input group_t g);
        return (g[0].mux != '0) || (g[1].mux != '0) || (g[2].mux != '0);
    endfunction

endpackage

// File: rtl/stage5_message_queue_module_if.sv
// Group-capture and slot-emit bus of the stage 5 message queue.
// The master drives the decoded group and the downstream ready; the slave is the queue.
interface stage5_message_queue_module_if #(
    parameter int FIFO_AW = 3
);
    import stage5_message_queue_module_pkg::*;

    logic                                 message_en_in;
    logic [MAX_MESSAGE_BITS-1:0]          message_1_in;
    logic [MAX_MESSAGE_BITS-1:0]          message_2_in;
    logic [MAX_MESSAGE_BITS-1:0]          message_3_in;
    logic [N_type_control_width-1:0]      N_type_control_m1_in;
    logic [N_type_control_width-1:0]      N_type_control_m2_in;
    logic [N_type_control_width-1:0]      N_type_control_m3_in;
    logic [message_mux_control_width-1:0] message_mux_control_m1_in;
    logic [message_mux_control_width-1:0] message_mux_control_m2_in;
    logic [message_mux_control_width-1:0] message_mux_control_m3_in;
    logic                                 msg_ready_in;

    logic                                 msg_valid_out;
    logic [MAX_MESSAGE_BITS-1:0]          msg_data_out;
    logic [N_type_control_width-1:0]      msg_N_type_out;
    logic [message_mux_control_width-1:0] msg_mux_control_out;
    logic [1:0]                           msg_slot_out;
    logic                                 msg_last_out;
    logic [FIFO_AW:0]                     fifo_level_out;
    logic [overflow_cnt_bits-1:0]         overflow_cnt_out;

    modport master (
        output message_en_in, message_1_in, message_2_in, message_3_in,
               N_type_control_m1_in, N_type_control_m2_in, N_type_control_m3_in,
               message_mux_control_m1_in, message_mux_control_m2_in, message_mux_control_m3_in,
               msg_ready_in,
        input  msg_valid_out, msg_data_out, msg_N_type_out, msg_mux_control_out,
               msg_slot_out, msg_last_out, fifo_level_out, overflow_cnt_out
    );

    modport slave (
        input  message_en_in, message_1_in, message_2_in, message_3_in,
               N_type_control_m1_in, N_type_control_m2_in, N_type_control_m3_in,
               message_mux_control_m1_in, message_mux_control_m2_in, message_mux_control_m3_in,
               msg_ready_in,
        output msg_valid_out, msg_data_out, msg_N_type_out, msg_mux_control_out,
               msg_slot_out, msg_last_out, fifo_level_out, overflow_cnt_out
    );

endinterface

// File: rtl/stage5_message_queue_module_group_fifo.sv
// Group FIFO: synchronous-write RAM with a registered read port plus pointer and level tracking.
// The caller only asserts wr_en when not full and rd_en when not empty.
module stage5_group_fifo_module #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;

    // RAM and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign rd_data = rd_data_reg;
    assign level   = level_reg;
    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign empty   = (level_reg == '0);

endmodule

// File: rtl/stage5_message_queue_module.sv
// Stage 5 message queue: buffers decoded groups and emits their slots over valid/ready.
// Macro STAGE5_SLOT_SKIP_EN: skip empty slots (mux control 0) and never store all-empty groups.
module stage5_message_queue_module
    import stage5_message_queue_module_pkg::*;
#(
    parameter int FIFO_DEPTH = stage5_fifo_depth,
    parameter int FIFO_AW    = stage5_fifo_aw
) (
    input logic clk,
    input logic rst_n,
    stage5_message_queue_module_if.slave bus
);

    group_t                       wr_group;
    group_t                       held_group;
    logic [stage5_group_bits-1:0] held_bits;
    logic                         group_ok;
    logic                         wr_en;
    logic                         drop;
    logic                         pop;
    logic                         full;
    logic                         empty;
    logic [FIFO_AW:0]             level;

    rd_state_t                    state_reg;
    logic [1:0]                   slot_reg;
    logic [overflow_cnt_bits-1:0] ovf_cnt_reg;
    logic [1:0]                   cur_slot;
    logic                         cur_last;

    assign wr_group[0] = '{mux: bus.message_mux_control_m1_in, n_type: bus.N_type_control_m1_in, data: bus.message_1_in};
    assign wr_group[1] = '{mux: bus.message_mux_control_m2_in, n_type: bus.N_type_control_m2_in, data: bus.message_2_in};
    assign wr_group[2] = '{mux: bus.message_mux_control_m3_in, n_type: bus.N_type_control_m3_in, data: bus.message_3_in};

`ifdef STAGE5_SLOT_SKIP_EN
    logic [2:0] slot_full;
    logic       later_full;

    assign group_ok = group_has_msg(wr_group);

    for (genvar gi = 0; gi < 3; gi++) begin : g_slot_full
        assign slot_full[gi] = (held_group[gi].mux != '0);
    end

    // slot_reg is the lowest slot still eligible; the emitted slot is the first non-empty one from there.
    always_comb begin
        cur_slot   = 2'd0;
        cur_last   = 1'b0;
        later_full = 1'b0;
        if (slot_reg != 2'd0) begin
            for (int i = 3; i >= 1; i--) begin
                if (i >= int'(slot_reg) && slot_full[i-1]) begin
                    cur_slot = 2'(i);
                end
            end
            for (int i = 1; i <= 3; i++) begin
                if (i > int'(cur_slot) && slot_full[i-1]) begin
                    later_full = 1'b1;
                end
            end
            cur_last = (cur_slot != 2'd0) && !later_full;
        end
    end
`else
    assign group_ok = 1'b1;

    always_comb begin
        cur_slot = slot_reg;
        cur_last = (slot_reg == 2'd3);
    end
`endif

    // Full is judged on the level before any same-cycle pop, so a strobe at full is always dropped.
    assign wr_en = bus.message_en_in && group_ok && !full;
    assign drop  = bus.message_en_in && group_ok && full;
    assign pop   = !empty && ((state_reg == IDLE) ||
                              ((state_reg == EMIT) && bus.msg_ready_in && cur_last));

    stage5_group_fifo_module #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW),
        .WIDTH (stage5_group_bits)
    ) u_group_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_group),
        .rd_en   (pop),
        .rd_data (held_bits),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    assign held_group = group_t'(held_bits);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            slot_reg    <= 2'd0;
            ovf_cnt_reg <= '0;
        end else begin
            if (drop && (ovf_cnt_reg != '1)) begin
                ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (!empty) begin
                        state_reg <= EMIT;
                        slot_reg  <= 2'd1;
                    end
                end
                EMIT: begin
                    if (bus.msg_ready_in) begin
                        if (!cur_last) begin
                            slot_reg <= cur_slot + 2'd1;
                        end else if (!empty) begin
                            slot_reg <= 2'd1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Outputs come from the holding register and slot cursor, so they stay put while idle.
    assign bus.msg_valid_out       = (state_reg == EMIT);
    assign bus.msg_slot_out        = cur_slot;
    assign bus.msg_last_out        = cur_last;
    assign bus.msg_data_out        = (cur_slot == 2'd0) ? '0 : held_group[cur_slot - 2'd1].data;
    assign bus.msg_N_type_out      = (cur_slot == 2'd0) ? '0 : held_group[cur_slot - 2'd1].n_type;
    assign bus.msg_mux_control_out = (cur_slot == 2'd0) ? '0 : held_group[cur_slot - 2'd1].mux;
    assign bus.fifo_level_out      = level;
    assign bus.overflow_cnt_out    = ovf_cnt_reg;

endmodule
